reg_file_16x8: RTL and testbench



---
 rtl/reg_file_16x8.sv | 81 ++++++++
 tb/tb_reg_file_16x8.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_16x8.sv
// ---------------------------------------------------------------------------
// reg_file_16x8
//   Sixteen-entry by WIDTH-bit register file. Entries 0-7 are the
//   architectural registers R0-R7. Entries 8-15 are microcode temporaries
//   that only the AX/BX/DX microinstruction fields can reach.
//
//   Ports: one synchronous write port (RW/DA/D_in), two combinational
//   operand read ports (AA->A_data, BA->B_data) and one combinational
//   debug read port (dbg_addr->dbg_data) for the board display.
//   wr_count counts committed writes and wraps at 8 bits.
//
//   Handshake: there is none. A write is committed on every rising clk
//   edge where rst_n is high and RW is high. No ready/valid pair exists,
//   so the block can never stall.
//
//   Configuration macro: REGFILE_BYPASS_EN
//     defined   - A_data and B_data forward D_in in the same cycle when
//                 RW=1 and their read address equals DA. dbg_data is never
//                 forwarded.
//     undefined - all read ports return the stored array value, so a
//                 same-cycle read of DA shows the old contents until the
//                 clock edge.
//
//   Reset: asynchronous and active-low. It clears every entry and
//   wr_count immediately, and it wins over a write on the same edge.
// ---------------------------------------------------------------------------
module reg_file_16x8 #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RW,
   input  logic [DEPTH_LOG2-1:0] DA,
   input  logic [DEPTH_LOG2-1:0] AA,
   input  logic [DEPTH_LOG2-1:0] BA,
   input  logic [WIDTH-1:0]      D_in,
   output logic [WIDTH-1:0]      A_data,
   output logic [WIDTH-1:0]      B_data,
   input  logic [DEPTH_LOG2-1:0] dbg_addr,
   output logic [WIDTH-1:0]      dbg_data,
   output logic [7:0]            wr_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Storage array. No hardwired-zero entry: R0 is an ordinary register.
   logic [WIDTH-1:0] regs [DEPTH];
   logic [7:0]       wr_count_q;

   // Write port and write counter. Reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         wr_count_q <= '0;
      end else if (RW) begin
         regs[DA]   <= D_in;
         wr_count_q <= wr_count_q + 8'd1;
      end
   end

   // Operand read ports, with optional same-cycle write-through forwarding.
   always_comb begin
      A_data = regs[AA];
      B_data = regs[BA];
`ifdef REGFILE_BYPASS_EN
      if (RW && (AA == DA)) A_data = D_in;
      if (RW && (BA == DA)) B_data = D_in;
`endif
   end

   // The debug port always shows the stored value and is never forwarded.
   always_comb begin
      dbg_data = regs[dbg_addr];
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_16x8.sv
// ---------------------------------------------------------------------------
// tb_reg_file_16x8
//   Self-checking bench for reg_file_16x8. A reference model (a plain array
//   plus a counter) is updated from the architectural rules. Expected read
//   values are taken from that model before and after each clock edge.
//   Honours REGFILE_BYPASS_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_reg_file_16x8;

   localparam int WIDTH = 8;
   localparam int AW    = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT ----------------
   logic            rw;
   logic [AW-1:0]   da, aa, ba, dbg_addr;
   logic [WIDTH-1:0] d_in, a_data, b_data, dbg_data;
   logic [7:0]      wr_count;

   reg_file_16x8 #(.WIDTH(WIDTH), .DEPTH_LOG2(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RW       (rw),
      .DA       (da),
      .AA       (aa),
      .BA       (ba),
      .D_in     (d_in),
      .A_data   (a_data),
      .B_data   (b_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .wr_count (wr_count)
   );

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] model_mem [16];
   logic [7:0]       model_cnt;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      model_cnt = '0;
   endtask

   function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] addr,
                                                   input bit fwd);
      if (fwd && BYPASS && rw && (addr == da)) return d_in;
      return model_mem[addr];
   endfunction

   // ---------------- scoreboard ----------------
   int n_compared;
   int n_mismatched;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic check_reads(input string tag);
      check({tag, ".A"},   a_data,   model_read(aa, 1'b1));
      check({tag, ".B"},   b_data,   model_read(ba, 1'b1));
      check({tag, ".dbg"}, dbg_data, model_read(dbg_addr, 1'b0));
      check({tag, ".cnt"}, wr_count, model_cnt);
   endtask

   // ---------------- driver ----------------
   // One full cycle: drive at negedge, check before the edge, step the
   // model at the edge, check again just after it.
   task automatic drive_cycle(input logic w, input logic [AW-1:0] d_a,
                              input logic [AW-1:0] a_a, input logic [AW-1:0] b_a,
                              input logic [WIDTH-1:0] dat,
                              input logic [AW-1:0] dbg_a, input string tag);
      @(negedge clk);
      rw = w; da = d_a; aa = a_a; ba = b_a; d_in = dat; dbg_addr = dbg_a;
      #1;
      check_reads({tag, ".pre"});
      @(posedge clk);
      if (w) begin
         model_mem[d_a] = dat;
         model_cnt      = model_cnt + 8'd1;
      end
      #1;
      check_reads({tag, ".post"});
   endtask

   task automatic write_quiet(input logic [AW-1:0] d_a, input logic [WIDTH-1:0] dat);
      @(negedge clk);
      rw = 1'b1; da = d_a; d_in = dat;
      @(posedge clk);
      model_mem[d_a] = dat;
      model_cnt      = model_cnt + 8'd1;
   endtask

   task automatic check_all_entries(input string tag);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = i[AW-1:0];
         #0.1;
         check(tag, dbg_data, model_mem[i]);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] cnt_before;
   logic [WIDTH-1:0] val;

   initial begin
      n_compared = 0; n_mismatched = 0;
      rw = 0; da = 0; aa = 0; ba = 0; d_in = 0; dbg_addr = 0;
      rst_n = 1'b0;
      model_reset();
      #12;
      check_reads("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Fill every entry with 0xFF, then assert reset mid-cycle.
      for (int i = 0; i < 16; i++) write_quiet(i[AW-1:0], 8'hFF);
      @(negedge clk);
      rw = 1'b0; aa = 4'd3; ba = 4'd14; dbg_addr = 4'd9;
      #1;
      check_reads("filled");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reads("async_rst");
      check_all_entries("async_rst.entry");
      @(negedge clk);
      rst_n = 1'b1;

      // Write 0x3C to R5, read on both ports.
      drive_cycle(1'b1, 4'd5, 4'd5, 4'd5, 8'h3C, 4'd5, "w5");
      check("w5.count_is_1", wr_count, 32'd1);

      // Temporary entry 12 is distinct from entry 4.
      drive_cycle(1'b1, 4'd12, 4'd12, 4'd4, 8'hA5, 4'd12, "w12");
      drive_cycle(1'b0, 4'd0, 4'd12, 4'd4, 8'h00, 4'd12, "r12");
      check("r12.entry4_zero", b_data, 32'h0);

      // RW=0 for three cycles: no change.
      cnt_before = wr_count;
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'd3, 4'd3, 4'd3, 8'h77, 4'd3, "rw0");
      check("rw0.entry3", dbg_data, 32'h0);
      check("rw0.count", wr_count, cnt_before);

      // Same-cycle write/read of R7.
      drive_cycle(1'b1, 4'd7, 4'd0, 4'd0, 8'h11, 4'd7, "w7a");
      @(negedge clk);
      rw = 1'b1; da = 4'd7; d_in = 8'h22; aa = 4'd7; ba = 4'd5; dbg_addr = 4'd7;
      #1;
      check("fwd7.A_pre", a_data, BYPASS ? 32'h22 : 32'h11);
      check("fwd7.dbg_pre", dbg_data, 32'h11);
      @(posedge clk);
      model_mem[7] = 8'h22; model_cnt = model_cnt + 8'd1;
      #1;
      check("fwd7.A_post", a_data, 32'h22);
      check_reads("fwd7.post");

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), "rand");
      end
      check_all_entries("rand.entry");

      // 256 writes from reset: the counter wraps back to 0.
      @(negedge clk);
      rst_n = 1'b0; rw = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         val = 8'($urandom_range(0, 255));
         write_quiet(4'($urandom_range(0, 15)), val);
         if (i == 254) begin
            #1;
            check("wrap.count_255", wr_count, 32'd255);
         end
      end
      #1;
      check("wrap.count_0", wr_count, 32'd0);
      check("wrap.model", wr_count, model_cnt);
      check_all_entries("wrap.entry");

      // Reset held across a write edge: the write is dropped.
      @(negedge clk);
      rw = 1'b1; da = 4'd9; d_in = 8'h5A; aa = 4'd9; ba = 4'd9; dbg_addr = 4'd9;
      #4;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check("rst_edge.A", a_data, 32'h0);
      check("rst_edge.cnt", wr_count, 32'h0);
      @(negedge clk);
      rw = 1'b0;
      rst_n = 1'b1;
      #1;
      check_reads("rst_edge.after");
      check("rst_edge.entry9", dbg_data, 32'h0);

      // Writes resume on the first edge with rst_n high.
      drive_cycle(1'b1, 4'd9, 4'd9, 4'd0, 8'hC3, 4'd9, "resume");
      check("resume.entry9", dbg_data, 32'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      n_mismatched++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
